// File: rtl/div_unit_pkg.sv
// Shared encodings for the execute-stage RV32M divider: operation select
// (also produced by the control unit) and divider FSM states.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

   function automatic logic op_is_signed(input div_op_t op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(input div_op_t op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Holds the pipeline via stall_o until the single-cycle done_o result pulse.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [1:0]            div_ctrl_i,
   input  logic [DATA_WIDTH-1:0] op_a_i,
   input  logic [DATA_WIDTH-1:0] op_b_i,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  done_o,
   output logic                  stall_o,
   output logic                  busy_o
);

   localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   // Two's complement negate; |MIN_NEG| stays MIN_NEG, read as unsigned.
   function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] x,
                                                      input logic                  neg);
      return neg ? (ZERO - x) : x;
   endfunction

   div_state_t            state_q, state_d;
   div_op_t               op_q, op_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] bmag_q, bmag_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;

   div_op_t               in_op;
   logic                  in_signed;
   logic                  in_rem;
   logic                  accept;
   logic                  special;
   logic [DATA_WIDTH:0]   rem_sh;
   logic [DATA_WIDTH:0]   trial;
   logic [DATA_WIDTH-1:0] rem_step;
   logic [DATA_WIDTH-1:0] quo_step;

   always_comb begin
      in_op     = div_op_t'(div_ctrl_i);
      in_signed = op_is_signed(in_op);
      in_rem    = op_is_rem(in_op);
      accept    = (state_q == IDLE) && start_i && !flush_i;
      special   = (op_b_i == ZERO) ||
                  (in_signed && (op_a_i == MIN_NEG) && (op_b_i == ALL_ONES));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      stall_o  = accept || (state_q == CALC);
      busy_o   = (state_q != IDLE);
      done_o   = (state_q == DONE);
      result_o = result_q;
   end

   // Trial subtract is one bit wider so unsigned divisors above 2^(W-1) work.
   always_comb begin
      rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
      trial    = rem_sh - {1'b0, bmag_q};
      rem_step = trial[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
      quo_step = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
   end

   always_comb begin
      op_d      = op_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      bmag_d    = bmag_q;
      result_d  = result_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = in_op;
               cnt_d     = CNT_LAST;
               quo_d     = cond_neg(op_a_i, in_signed && op_a_i[DATA_WIDTH-1]);
               rem_d     = ZERO;
               bmag_d    = cond_neg(op_b_i, in_signed && op_b_i[DATA_WIDTH-1]);
               neg_quo_d = in_signed && (op_a_i[DATA_WIDTH-1] ^ op_b_i[DATA_WIDTH-1]);
               neg_rem_d = in_signed && op_a_i[DATA_WIDTH-1];
               if (op_b_i == ZERO) begin
                  result_d = in_rem ? op_a_i : ALL_ONES;
               end else if (special) begin
                  result_d = in_rem ? ZERO : MIN_NEG;
               end
            end
         end
         CALC: begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == '0) begin
               result_d = op_is_rem(op_q) ? cond_neg(rem_step, neg_rem_q)
                                          : cond_neg(quo_step, neg_quo_q);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q      <= DIV;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         bmag_q    <= '0;
         result_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         bmag_q    <= bmag_d;
         result_q  <= result_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall window, signed/unsigned results,
// RISC-V special cases, flush/reset aborts and back-to-back operations.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_i;
   logic [1:0]   div_ctrl_i;
   logic [W-1:0] op_a_i;
   logic [W-1:0] op_b_i;
   logic         flush_i;
   logic [W-1:0] result_o;
   logic         done_o;
   logic         stall_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;

   div_unit #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .div_ctrl_i (div_ctrl_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .flush_i    (flush_i),
      .result_o   (result_o),
      .done_o     (done_o),
      .stall_o    (stall_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Start held from cycle 0 until the done cycle; operands scrambled after acceptance.
   task automatic run_op(input string tag, input logic [1:0] ctrl,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat);
      int  cyc       = 0;
      int  stall_cnt = 0;
      bit  seen      = 1'b0;
      @(posedge clk); #1;
      start_i    = 1'b1;
      div_ctrl_i = ctrl;
      op_a_i     = a;
      op_b_i     = b;
      while (!seen && cyc <= 45) begin
         @(negedge clk);
         if (done_o) begin
            seen = 1'b1;
         end else begin
            if (stall_o) stall_cnt++;
            cyc++;
            if (cyc == 3) begin
               op_a_i = ~a;
               op_b_i = b + 32'd5;
            end
         end
      end
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_result"}, result_o, exp);
      chk({tag, "_stall_cycles"}, stall_cnt, lat);
      chk({tag, "_stall_in_done"}, {31'b0, stall_o}, 32'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      chk({tag, "_done_single"}, {31'b0, done_o}, 32'd0);
      chk({tag, "_idle_after"}, {31'b0, busy_o}, 32'd0);
   endtask

   initial begin
      int n_done;
      int d1;
      int d2;
      logic [W-1:0] r1;
      logic [W-1:0] r2;

      rst_n      = 1'b0;
      start_i    = 1'b0;
      flush_i    = 1'b0;
      div_ctrl_i = 2'b00;
      op_a_i     = '0;
      op_b_i     = '0;

      @(posedge clk);
      @(negedge clk);
      chk("rst_result", result_o, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op("div_100_7",    DIV,  32'd100,      32'd7,        32'd14,       33);
      run_op("rem_100_7",    REM,  32'd100,      32'd7,        32'd2,        33);
      run_op("div_m100_7",   DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
      run_op("rem_m100_7",   REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);
      run_op("rem_100_m7",   REM,  32'd100,      32'hFFFFFFF9, 32'd2,        33);
      run_op("divu_max_2",   DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
      run_op("remu_max_2",   REMU, 32'hFFFFFFFF, 32'd2,        32'd1,        33);
      run_op("divu_big_div", DIVU, 32'hFFFFFFFF, 32'hF0000000, 32'd1,        33);
      run_op("div_by_zero",  DIV,  32'h00001234, 32'd0,        32'hFFFFFFFF, 1);
      run_op("remu_by_zero", REMU, 32'h00001234, 32'd0,        32'h00001234, 1);
      run_op("div_ovf",      DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",      REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // Flush during CALC at cycle 10; the flushed instruction drops start.
      @(posedge clk); #1;
      start_i = 1'b1; div_ctrl_i = DIV; op_a_i = 32'd100; op_b_i = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1; start_i = 1'b0;
      @(negedge clk);
      chk("flush_busy_c10", {31'b0, busy_o}, 32'd1);
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_idle_c11", {31'b0, busy_o}, 32'd0);
      chk("flush_stall_c11", {31'b0, stall_o}, 32'd0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o) n_done++;
      end
      chk("flush_no_done", n_done, 0);

      // Reset at cycle 20 of another operation.
      @(posedge clk); #1;
      start_i = 1'b1; div_ctrl_i = DIVU; op_a_i = 32'd1000; op_b_i = 32'd3;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0; start_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_idle", {31'b0, busy_o}, 32'd0);
      chk("rstmid_stall", {31'b0, stall_o}, 32'd0);
      chk("rstmid_result", result_o, 32'd0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o) n_done++;
      end
      chk("rstmid_no_done", n_done, 0);

      run_op("div_9_3", DIV, 32'd9, 32'd3, 32'd3, 33);

      // Back-to-back DIVU with start held: second start seen in cycle 34, done 33 later.
      @(posedge clk); #1;
      start_i = 1'b1; div_ctrl_i = DIVU; op_a_i = 32'd20; op_b_i = 32'd4;
      n_done = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
      for (int c = 0; c < 75; c++) begin
         @(negedge clk);
         if (done_o) begin
            n_done++;
            if (n_done == 1) begin d1 = c; r1 = result_o; end
            else begin d2 = c; r2 = result_o; end
         end
         @(posedge clk); #1;
         if (n_done == 1) op_a_i = 32'd21;
         if (n_done >= 2) start_i = 1'b0;
      end
      chk("b2b_done_count", n_done, 2);
      chk("b2b_done1_cycle", d1, 33);
      chk("b2b_done2_cycle", d2, 67);
      chk("b2b_result1", r1, 32'd5);
      chk("b2b_result2", r2, 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
